// File: rtl/barrel_unrotate.sv
// Iterative barrel un-rotator: op[j] = ip[(j+rot) % NUM_ELEMS].
// One log2 shift layer per clock, sequenced by an IDLE/SHIFT/HOLD FSM with a start/rdy/valid/ack handshake.
module barrel_unrotate #(
  parameter int NUM_ELEMS  = 64,
  parameter int DATA_WIDTH = 8,
  parameter int ROT_WIDTH  = $clog2(NUM_ELEMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ip [0:NUM_ELEMS-1],
  input  logic [ROT_WIDTH-1:0]  rot,
  input  logic                  start,
  input  logic                  ack,
  output logic [DATA_WIDTH-1:0] op [0:NUM_ELEMS-1],
  output logic                  rdy,
  output logic                  valid
);

  localparam int NUM_LAYERS = $clog2(NUM_ELEMS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q [0:NUM_ELEMS-1];
  logic [DATA_WIDTH-1:0] data_d [0:NUM_ELEMS-1];
  logic [ROT_WIDTH-1:0]  rot_q, rot_d;
  logic [ROT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rdy_q, rdy_d;
  logic                  valid_q, valid_d;
  logic [ROT_WIDTH-1:0]  rot_sh_s;
  logic [ROT_WIDTH-1:0]  dist_s;
  logic [ROT_WIDTH-1:0]  src_s;

  // Next-state, datapath and handshake output computation
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rot_d    = rot_q;
    cnt_d    = cnt_q;
    rot_sh_s = rot_q >> cnt_q;
    dist_s   = ROT_WIDTH'(1) << cnt_q;
    src_s    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = ip;
          rot_d   = rot;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Index arithmetic wraps naturally because NUM_ELEMS is a power of two.
        if (rot_sh_s[0]) begin
          for (int j = 0; j < NUM_ELEMS; j++) begin
            src_s     = ROT_WIDTH'(j) + dist_s;
            data_d[j] = data_q[src_s];
          end
        end else begin
          data_d = data_q;
        end
        if (cnt_q == ROT_WIDTH'(NUM_LAYERS - 1)) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + ROT_WIDTH'(1);
        end
      end
      HOLD: begin
        if (ack) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d   = (state_d == IDLE);
    valid_d = (state_d == HOLD);
  end

  // State, data and output flops with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '{default: '0};
      rot_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rot_q   <= rot_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      valid_q <= valid_d;
    end
  end

  assign op    = data_q;
  assign rdy   = rdy_q;
  assign valid = valid_q;

endmodule
